// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared encodings for the EX/MEM stage: access sizes, FSM
//               states, write-back selects and the wait-counter width.
// Revision    : 1.0
// ============================================================================
package mem_pkg;

    localparam logic [1:0] SEL_BYTE = 2'b00;
    localparam logic [1:0] SEL_HALF = 2'b01;
    localparam logic [1:0] SEL_ILL  = 2'b10;
    localparam logic [1:0] SEL_WORD = 2'b11;

    localparam int CTR_W = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10,
        WB_IMM = 2'b11
    } wb_sel_t;

    // The reserved size code is always treated as misaligned.
    function automatic logic is_misaligned(input logic [1:0] sel, input logic [1:0] adr_lo);
        logic mis;
        case (sel)
            SEL_BYTE: mis = 1'b0;
            SEL_HALF: mis = adr_lo[0];
            SEL_WORD: mis = (adr_lo != 2'b00);
            default:  mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_ctr.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_ctr
// Description : Loadable down-counter timing an external-RAM access; flags
//               the final cycle (count==1) and any non-zero count.
// Revision    : 1.0
// ============================================================================
module mem_wait_ctr
    import mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_hold,
    input  logic             i_load,
    input  logic [CTR_W-1:0] i_load_val,
    output logic             o_last,
    output logic             o_busy
);

    logic [CTR_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (!i_hold) begin
            if (i_load) begin
                r_count <= i_load_val;
            end else if (r_count != '0) begin
                r_count <= r_count - CTR_W'(1);
            end
        end
    end

    assign o_last = (r_count == CTR_W'(1));
    assign o_busy = (r_count != '0);

endmodule
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_stage
// Description : EX/MEM pipeline register; holds loads/stores for RAM_LAT
//               cycles under a suspend request. Optional macro:
//               MEM_MISALIGN_CHECK_EN (misalignment flag + write suppression).
// Revision    : 1.0
// ============================================================================
module ex_mem_stage
    import mem_pkg::*;
#(
    parameter int RAM_LAT = 1,
    parameter int ADR_W   = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             ex_valid_i,
    input  logic [31:0]      ex_alu_result_i,
    input  logic [31:0]      ex_rs2_data_i,
    input  logic             ex_mem_we_i,
    input  logic             ex_mem_re_i,
    input  logic [1:0]       ex_mem_data_sel_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_rf_we_i,
    input  logic [1:0]       ex_wb_sel_i,
    input  logic [31:0]      ex_pc_i,
    output logic             mem_valid_o,
    output logic             mem_we_o,
    output logic [ADR_W-1:0] adr_o,
    output logic [31:0]      wd_o,
    output logic [1:0]       mem_data_sel_o,
    output logic [4:0]       mem_rd_o,
    output logic             mem_rf_we_o,
    output logic [1:0]       mem_wb_sel_o,
    output logic [31:0]      mem_alu_result_o,
    output logic [31:0]      mem_pc_o,
    output logic             suspend_o,
    output logic             misalign_o
);

    localparam logic [CTR_W-1:0] c_lat      = CTR_W'(RAM_LAT);
    localparam logic             c_has_wait = (RAM_LAT != 0);

    state_t      r_state;
    logic        r_valid;
    logic        r_we;
    logic        r_misalign;
    logic        r_serviced;
    logic [31:0] r_alu;
    logic [31:0] r_wd;
    logic [1:0]  r_sel;
    logic [4:0]  r_rd;
    logic        r_rf_we;
    logic [1:0]  r_wb_sel;
    logic [31:0] r_pc;

    logic [1:0]  w_sel_in;
    logic        w_mis_in;
    logic        w_access_in;
    logic        w_capture;
    logic        w_enter_wait;
    logic        w_last;
    logic        w_busy;

`ifdef MEM_MISALIGN_CHECK_EN
    assign w_sel_in = ex_mem_data_sel_i;
    assign w_mis_in = is_misaligned(ex_mem_data_sel_i, ex_alu_result_i[1:0]);
`else
    assign w_sel_in = (ex_mem_data_sel_i == SEL_ILL) ? SEL_WORD : ex_mem_data_sel_i;
    assign w_mis_in = 1'b0;
`endif

    assign w_access_in  = ex_valid_i & ~flush_i & (ex_mem_we_i | ex_mem_re_i);
    assign w_capture    = (r_state == ST_IDLE) & (~stall_i | flush_i);
    assign w_enter_wait = w_capture & w_access_in & ~w_mis_in & c_has_wait;

    mem_wait_ctr u_wait_ctr (
        .clk        (clk_i),
        .rst_n      (reset_i),
        .i_clear    (flush_i),
        .i_hold     (stall_i),
        .i_load     (w_enter_wait),
        .i_load_val (c_lat),
        .o_last     (w_last),
        .o_busy     (w_busy)
    );

    // r_serviced marks the IDLE cycle after a completed WAIT so the store
    // is not written a second time while the register still holds it.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state    <= ST_IDLE;
            r_valid    <= 1'b0;
            r_we       <= 1'b0;
            r_misalign <= 1'b0;
            r_serviced <= 1'b0;
            r_alu      <= '0;
            r_wd       <= '0;
            r_sel      <= '0;
            r_rd       <= '0;
            r_rf_we    <= 1'b0;
            r_wb_sel   <= '0;
            r_pc       <= '0;
        end else if (r_state == ST_WAIT) begin
            if (flush_i) begin
                r_state <= ST_IDLE;
                r_valid <= 1'b0;
            end else if (!stall_i && w_last) begin
                r_state    <= ST_IDLE;
                r_serviced <= 1'b1;
            end
        end else if (w_capture) begin
            r_state    <= w_enter_wait ? ST_WAIT : ST_IDLE;
            r_valid    <= ex_valid_i & ~flush_i;
            r_we       <= ex_mem_we_i;
            r_misalign <= w_access_in & w_mis_in;
            r_serviced <= 1'b0;
            r_alu      <= ex_alu_result_i;
            r_wd       <= ex_rs2_data_i;
            r_sel      <= w_sel_in;
            r_rd       <= ex_rd_i;
            r_rf_we    <= ex_rf_we_i;
            r_wb_sel   <= ex_wb_sel_i;
            r_pc       <= ex_pc_i;
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    assign adr_o = r_alu[ADR_W-1:0];
`else
    always_comb begin
        adr_o = r_alu[ADR_W-1:0];
        if (r_sel == SEL_HALF) begin
            adr_o[0] = 1'b0;
        end else if (r_sel == SEL_WORD) begin
            adr_o[1:0] = 2'b00;
        end
    end
`endif

    assign mem_we_o = r_valid & r_we & ~r_misalign & ~r_serviced &
                      ((r_state == ST_IDLE) | (w_last & ~flush_i));

    assign mem_valid_o      = r_valid;
    assign wd_o             = r_wd;
    assign mem_data_sel_o   = r_sel;
    assign mem_rd_o         = r_rd;
    assign mem_rf_we_o      = r_valid & r_rf_we & ~r_misalign;
    assign mem_wb_sel_o     = r_wb_sel;
    assign mem_alu_result_o = r_alu;
    assign mem_pc_o         = r_pc;
    assign suspend_o        = w_busy;
    assign misalign_o       = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_stage
// Description : Directed bench for ex_mem_stage (RAM_LAT=2 and RAM_LAT=0)
//               with a write-transaction scoreboard.
// Revision    : 1.0
// ============================================================================
module tb_ex_mem_stage;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        stall_i;
    logic        flush_i;
    logic        ex_valid_i;
    logic [31:0] ex_alu_result_i;
    logic [31:0] ex_rs2_data_i;
    logic        ex_mem_we_i;
    logic        ex_mem_re_i;
    logic [1:0]  ex_mem_data_sel_i;
    logic [4:0]  ex_rd_i;
    logic        ex_rf_we_i;
    logic [1:0]  ex_wb_sel_i;
    logic [31:0] ex_pc_i;

    logic        a_valid, a_we, a_rf_we, a_suspend, a_misalign;
    logic [15:0] a_adr;
    logic [31:0] a_wd, a_alu, a_pc;
    logic [1:0]  a_sel, a_wb_sel;
    logic [4:0]  a_rd;

    logic        z_valid, z_we, z_rf_we, z_suspend, z_misalign;
    logic [15:0] z_adr;
    logic [31:0] z_wd, z_alu, z_pc;
    logic [1:0]  z_sel, z_wb_sel;
    logic [4:0]  z_rd;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int n_we     = 0;
    int we0;
    int susp;

    logic [47:0] exp_q[$];
    logic [47:0] obs_q[$];

    always #5 clk_i = ~clk_i;

    ex_mem_stage #(.RAM_LAT(2), .ADR_W(16)) u_dut (
        .clk_i(clk_i), .reset_i(reset_i), .stall_i(stall_i), .flush_i(flush_i),
        .ex_valid_i(ex_valid_i), .ex_alu_result_i(ex_alu_result_i),
        .ex_rs2_data_i(ex_rs2_data_i), .ex_mem_we_i(ex_mem_we_i),
        .ex_mem_re_i(ex_mem_re_i), .ex_mem_data_sel_i(ex_mem_data_sel_i),
        .ex_rd_i(ex_rd_i), .ex_rf_we_i(ex_rf_we_i), .ex_wb_sel_i(ex_wb_sel_i),
        .ex_pc_i(ex_pc_i),
        .mem_valid_o(a_valid), .mem_we_o(a_we), .adr_o(a_adr), .wd_o(a_wd),
        .mem_data_sel_o(a_sel), .mem_rd_o(a_rd), .mem_rf_we_o(a_rf_we),
        .mem_wb_sel_o(a_wb_sel), .mem_alu_result_o(a_alu), .mem_pc_o(a_pc),
        .suspend_o(a_suspend), .misalign_o(a_misalign)
    );

    ex_mem_stage #(.RAM_LAT(0), .ADR_W(16)) u_dut0 (
        .clk_i(clk_i), .reset_i(reset_i), .stall_i(stall_i), .flush_i(flush_i),
        .ex_valid_i(ex_valid_i), .ex_alu_result_i(ex_alu_result_i),
        .ex_rs2_data_i(ex_rs2_data_i), .ex_mem_we_i(ex_mem_we_i),
        .ex_mem_re_i(ex_mem_re_i), .ex_mem_data_sel_i(ex_mem_data_sel_i),
        .ex_rd_i(ex_rd_i), .ex_rf_we_i(ex_rf_we_i), .ex_wb_sel_i(ex_wb_sel_i),
        .ex_pc_i(ex_pc_i),
        .mem_valid_o(z_valid), .mem_we_o(z_we), .adr_o(z_adr), .wd_o(z_wd),
        .mem_data_sel_o(z_sel), .mem_rd_o(z_rd), .mem_rf_we_o(z_rf_we),
        .mem_wb_sel_o(z_wb_sel), .mem_alu_result_o(z_alu), .mem_pc_o(z_pc),
        .suspend_o(z_suspend), .misalign_o(z_misalign)
    );

    // Every write strobe seen on the RAM_LAT=2 instance becomes one observed transaction.
    always @(negedge clk_i) begin
        if (reset_i && a_we) begin
            obs_q.push_back({a_adr, a_wd});
            n_we++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_drain(input string tag);
        logic [47:0] e;
        logic [47:0] o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 48'hx;
            chk({tag, "_sb_adr"}, {16'h0, o[47:32]}, {16'h0, e[47:32]});
            chk({tag, "_sb_wd"}, o[31:0], e[31:0]);
        end
        chk({tag, "_sb_extra"}, 32'(obs_q.size()), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic we, input logic re, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] rs2,
                         input logic [4:0] rd, input logic rfw, input logic [31:0] pc);
        ex_valid_i        = 1'b1;
        ex_mem_we_i       = we;
        ex_mem_re_i       = re;
        ex_mem_data_sel_i = sel;
        ex_alu_result_i   = alu;
        ex_rs2_data_i     = rs2;
        ex_rd_i           = rd;
        ex_rf_we_i        = rfw;
        ex_wb_sel_i       = re ? 2'b01 : 2'b00;
        ex_pc_i           = pc;
    endtask

    task automatic bubble();
        ex_valid_i  = 1'b0;
        ex_mem_we_i = 1'b0;
        ex_mem_re_i = 1'b0;
        ex_rf_we_i  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        ex_alu_result_i = '0; ex_rs2_data_i = '0; ex_mem_data_sel_i = '0;
        ex_rd_i = '0; ex_wb_sel_i = '0; ex_pc_i = '0;
        bubble();
        repeat (2) tick();
        chk("rst_valid", 32'(a_valid), 0);
        chk("rst_suspend", 32'(a_suspend), 0);
        chk("rst_adr", 32'(a_adr), 0);
        chk("rst_we", 32'(a_we), 0);
        chk("rst_misalign", 32'(a_misalign), 0);
        chk("rst_z_valid", 32'(z_valid), 0);
        reset_i = 1'b1;
        tick();

        // lw, two-cycle hold
        we0 = n_we;
        drive(1'b0, 1'b1, 2'b11, 32'h0000_0104, 32'h0, 5'd5, 1'b1, 32'h100);
        tick(); bubble();
        chk("lw_suspend_c1", 32'(a_suspend), 1);
        chk("lw_adr", 32'(a_adr), 32'h0104);
        chk("lw_sel", 32'(a_sel), 32'h3);
        chk("lw_we_c1", 32'(a_we), 0);
        chk("lw_valid", 32'(a_valid), 1);
        chk("lw_rd", 32'(a_rd), 5);
        chk("lw_rfwe", 32'(a_rf_we), 1);
        chk("lw_wbsel", 32'(a_wb_sel), 1);
        tick();
        chk("lw_suspend_c2", 32'(a_suspend), 1);
        chk("lw_we_c2", 32'(a_we), 0);
        tick();
        chk("lw_suspend_end", 32'(a_suspend), 0);
        chk("lw_we_end", 32'(a_we), 0);
        drive(1'b0, 1'b0, 2'b11, 32'h55, 32'h0, 5'd7, 1'b1, 32'h104);
        tick(); bubble();
        chk("resume_pc", a_pc, 32'h104);
        chk("resume_alu", a_alu, 32'h55);
        chk("resume_suspend", 32'(a_suspend), 0);
        chk("lw_no_write", 32'(n_we - we0), 0);

        // sw, single write in the last access cycle
        we0 = n_we;
        exp_q.push_back({16'h0200, 32'hDEAD_BEEF});
        drive(1'b1, 1'b0, 2'b11, 32'h0000_0200, 32'hDEAD_BEEF, 5'd0, 1'b0, 32'h108);
        tick(); bubble();
        chk("sw_wd", a_wd, 32'hDEAD_BEEF);
        chk("sw_we_c1", 32'(a_we), 0);
        chk("sw_suspend_c1", 32'(a_suspend), 1);
        tick();
        chk("sw_we_c2", 32'(a_we), 1);
        tick();
        chk("sw_we_after", 32'(a_we), 0);
        chk("sw_suspend_after", 32'(a_suspend), 0);
        tick();
        chk("sw_we_count", 32'(n_we - we0), 1);
        sb_drain("sw");

`ifdef MEM_MISALIGN_CHECK_EN
        we0 = n_we;
        drive(1'b1, 1'b0, 2'b01, 32'h0000_0101, 32'h0000_BEEF, 5'd0, 1'b0, 32'h10C);
        tick(); bubble();
        chk("sh_mis_flag", 32'(a_misalign), 1);
        chk("sh_mis_we", 32'(a_we), 0);
        chk("sh_mis_suspend", 32'(a_suspend), 0);
        tick();
        drive(1'b0, 1'b1, 2'b11, 32'h0000_0102, 32'h0, 5'd9, 1'b1, 32'h110);
        tick(); bubble();
        chk("lw_mis_flag", 32'(a_misalign), 1);
        chk("lw_mis_rfwe", 32'(a_rf_we), 0);
        chk("lw_mis_suspend", 32'(a_suspend), 0);
        tick();
        chk("mis_no_write", 32'(n_we - we0), 0);
`else
        we0 = n_we;
        exp_q.push_back({16'h0100, 32'h0000_BEEF});
        drive(1'b1, 1'b0, 2'b01, 32'h0000_0101, 32'h0000_BEEF, 5'd0, 1'b0, 32'h10C);
        tick(); bubble();
        chk("sh_al_flag", 32'(a_misalign), 0);
        chk("sh_al_adr", 32'(a_adr), 32'h0100);
        chk("sh_al_suspend", 32'(a_suspend), 1);
        tick();
        chk("sh_al_we", 32'(a_we), 1);
        tick(); tick();
        chk("sh_al_count", 32'(n_we - we0), 1);
        sb_drain("sh_al");
        drive(1'b0, 1'b1, 2'b10, 32'h0000_0102, 32'h0, 5'd9, 1'b1, 32'h110);
        tick(); bubble();
        chk("ill_sel", 32'(a_sel), 32'h3);
        chk("ill_adr", 32'(a_adr), 32'h0100);
        chk("ill_flag", 32'(a_misalign), 0);
        chk("ill_rfwe", 32'(a_rf_we), 1);
        tick(); tick();
        chk("ill_suspend_end", 32'(a_suspend), 0);
`endif

        // flush in the first WAIT cycle aborts the store
        we0 = n_we;
        drive(1'b1, 1'b0, 2'b11, 32'h0000_0300, 32'h1111_2222, 5'd0, 1'b0, 32'h114);
        tick(); bubble();
        chk("fl_suspend_pre", 32'(a_suspend), 1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("fl_valid", 32'(a_valid), 0);
        chk("fl_suspend", 32'(a_suspend), 0);
        chk("fl_we", 32'(a_we), 0);
        tick(); tick();
        chk("fl_no_write", 32'(n_we - we0), 0);

        // three stalled cycles stretch the hold to 2+3 cycles
        we0 = n_we;
        exp_q.push_back({16'h0400, 32'h1234_5678});
        drive(1'b1, 1'b0, 2'b11, 32'h0000_0400, 32'h1234_5678, 5'd0, 1'b0, 32'h118);
        tick(); bubble();
        susp = 32'(a_suspend);
        stall_i = 1'b1;
        repeat (3) begin
            tick();
            susp += 32'(a_suspend);
            chk("st_we_frozen", 32'(a_we), 0);
        end
        stall_i = 1'b0;
        tick();
        susp += 32'(a_suspend);
        chk("st_we_final", 32'(a_we), 1);
        tick();
        susp += 32'(a_suspend);
        chk("st_suspend_total", 32'(susp), 5);
        chk("st_we_count", 32'(n_we - we0), 1);
        sb_drain("st");

        // asynchronous reset mid-WAIT drops the pending store
        we0 = n_we;
        drive(1'b1, 1'b0, 2'b11, 32'h0000_0500, 32'hCAFE_F00D, 5'd0, 1'b0, 32'h11C);
        tick(); bubble();
        chk("rs_suspend_pre", 32'(a_suspend), 1);
        #2 reset_i = 1'b0;
        #1;
        chk("rs_suspend", 32'(a_suspend), 0);
        chk("rs_valid", 32'(a_valid), 0);
        chk("rs_wd", a_wd, 0);
        chk("rs_adr", 32'(a_adr), 0);
        chk("rs_we", 32'(a_we), 0);
        chk("rs_pc", a_pc, 0);
        chk("rs_z_wd", z_wd, 0);
        tick();
        reset_i = 1'b1;
        drive(1'b0, 1'b1, 2'b11, 32'h0000_0600, 32'h0, 5'd3, 1'b1, 32'h200);
        tick(); bubble();
        chk("post_suspend", 32'(a_suspend), 1);
        chk("post_adr", 32'(a_adr), 32'h0600);
        chk("post_z_suspend", 32'(z_suspend), 0);
        chk("post_z_valid", 32'(z_valid), 1);
        chk("post_z_adr", 32'(z_adr), 32'h0600);
        tick();
        chk("post_z_suspend_c2", 32'(z_suspend), 0);
        chk("post_suspend_c2", 32'(a_suspend), 1);
        tick();
        chk("post_suspend_end", 32'(a_suspend), 0);
        chk("rs_no_write", 32'(n_we - we0), 0);

        // RAM_LAT=0 store writes in its capture cycle without suspending
        we0 = n_we;
        exp_q.push_back({16'h0700, 32'hA5A5_A5A5});
        drive(1'b1, 1'b0, 2'b11, 32'h0000_0700, 32'hA5A5_A5A5, 5'd0, 1'b0, 32'h204);
        tick(); bubble();
        chk("z_sw_we", 32'(z_we), 1);
        chk("z_sw_suspend", 32'(z_suspend), 0);
        tick();
        chk("z_sw_we_next", 32'(z_we), 0);
        tick();
        chk("a_sw_count", 32'(n_we - we0), 1);
        sb_drain("z_sw");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
